// File: rtl/usb_tx_serializer.sv
// USB full-speed TX line stage.
// Sends SYNC, then the packet bytes LSB-first with bit stuffing and NRZI
// encoding, then EOP. Bytes are popped from the TX buffer head as they are needed.
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [6:0] tx_byte_count,
    input  logic [7:0] tx_packet_data,
    input  logic [6:0] buffer_occupancy,
    output logic       get_tx_packet_data,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;       // cycle position inside the current bit
    logic [2:0]    bit_q, bit_d;       // current data bit; during a stuff, the bit before it
    logic          stuff_q, stuff_d;   // current symbol is an inserted 0
    logic [2:0]    ones_q, ones_d;     // consecutive 1s sent so far
    logic [7:0]    shreg_q, shreg_d;   // byte being sent (SYNC pattern first)
    logic [6:0]    left_q, left_d;     // bytes still to pull from the buffer
    logic          nrzi_q, nrzi_d;     // line level while encoding: 1 = J, 0 = K
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic       bit_end;
    logic       cur_bit;
    logic [2:0] ones_nx;
    logic [2:0] nxt_idx;

    // State register and all datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stuff_q <= 1'b0;
            ones_q  <= '0;
            shreg_q <= '0;
            left_q  <= '0;
            nrzi_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stuff_q <= stuff_d;
            ones_q  <= ones_d;
            shreg_q <= shreg_d;
            left_q  <= left_d;
            nrzi_q  <= nrzi_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state: decide the next line symbol at the end of each bit time
    always_comb begin
        state_d            = state_q;
        bit_d              = bit_q;
        stuff_d            = stuff_q;
        ones_d             = ones_q;
        shreg_d            = shreg_q;
        left_d             = left_q;
        nrzi_d             = nrzi_q;
        err_d              = err_q;
        done_d             = 1'b0;
        get_tx_packet_data = 1'b0;
        bit_end            = (state_q != IDLE) && (cnt_q == LAST);
        cnt_d              = (state_q == IDLE || bit_end) ? '0 : cnt_q + CW'(1);
        cur_bit            = stuff_q ? 1'b0 : shreg_q[bit_q];
        ones_nx            = cur_bit ? ones_q + 3'd1 : 3'd0;
        nxt_idx            = bit_q + 3'd1;

        case (state_q)
            IDLE: begin
                ones_d = '0;
                if (tx_start) begin
                    state_d = SYNC;
                    bit_d   = '0;
                    stuff_d = 1'b0;
                    shreg_d = 8'h80;
                    left_d  = tx_byte_count;
                    err_d   = (tx_byte_count == 7'd0);
                    nrzi_d  = 1'b0;  // first SYNC bit is 0: J -> K
                end
            end
            SYNC, DATA: begin
                if (bit_end) begin
                    ones_d = ones_nx;
                    if (ones_nx == 3'd6) begin
                        // Six 1s in a row: insert a 0 before anything else, including a load
                        stuff_d = 1'b1;
                        nrzi_d  = ~nrzi_q;
                    end else begin
                        stuff_d = 1'b0;
                        if (bit_q != 3'd7) begin
                            bit_d  = nxt_idx;
                            nrzi_d = shreg_q[nxt_idx] ? nrzi_q : ~nrzi_q;
                        end else if (left_q == 7'd0) begin
                            state_d = EOP_SE0;
                            bit_d   = '0;
                        end else if (buffer_occupancy == 7'd0) begin
                            // Underrun: abort straight into EOP
                            err_d   = 1'b1;
                            state_d = EOP_SE0;
                            bit_d   = '0;
                        end else begin
                            get_tx_packet_data = 1'b1;
                            shreg_d = tx_packet_data;
                            left_d  = left_q - 7'd1;
                            state_d = DATA;
                            bit_d   = '0;
                            nrzi_d  = tx_packet_data[0] ? nrzi_q : ~nrzi_q;
                        end
                    end
                end
            end
            EOP_SE0: begin
                if (bit_end) begin
                    if (bit_q == 3'd1) state_d = EOP_J;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            EOP_J: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ones_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line drive: SE0 during EOP, NRZI level while encoding, J otherwise
    always_comb begin
        dplus_out  = 1'b1;
        dminus_out = 1'b0;
        if (state_q == EOP_SE0) begin
            dplus_out  = 1'b0;
            dminus_out = 1'b0;
        end else if (state_q == SYNC || state_q == DATA) begin
            dplus_out  = nrzi_q;
            dminus_out = ~nrzi_q;
        end
    end

    assign tx_busy  = (state_q != IDLE);
    assign tx_done  = done_q;
    assign tx_error = err_q;

endmodule
